fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter SIZE, 64, datapath/address width in bits.
REQ-002 Parameter RESET_PC, 64'h0, PC value loaded on reset.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 PCen  input  1  from control unit; advance PC when instruction is valid.
REQ-006 PCSrc  input  1  from control unit; 1 = take branch_target, 0 = sequential.
REQ-007 branch_target  input  SIZE  redirect address.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  SIZE  read address, equals current PC.
REQ-010 imem_ack  input  1  read data valid on imem_rdata this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 inst  output  SIZE  to control unit; {32'b0, instruction word}.
REQ-013 inst_valid  output  1  inst holds a fetched, unconsumed instruction.
REQ-014 pc  output  SIZE  address of the instruction in inst.
REQ-015 fetch_count  output  32  instructions retired (PCen accepted), wraps 2^32-1 -> 0.

Function
REQ-016 FSM states: FETCH, VALID, HALT; reset state FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ack capture imem_rdata into inst, set inst_valid, go VALID next cycle.
REQ-018 imem_ack in the same cycle imem_req rises is accepted (zero-wait memory gives 1-cycle fetch latency).
REQ-019 imem_ack is ignored in any state other than FETCH.
REQ-020 VALID: imem_req=0; inst and pc held stable until PCen=1.
REQ-021 VALID with PCen=1: pc <= PCSrc ? branch_target : pc+4 (mod 2^SIZE), inst_valid <= 0, fetch_count +1, go FETCH.
REQ-022 PCen and PCSrc are ignored in FETCH and HALT.
REQ-023 pc+4 at 2^SIZE-4 wraps to 0 with no error.
REQ-024 HALT: imem_req=0, inst_valid=0, pc frozen; exits only through reset.

Reset
REQ-025 rst_n=0 at a clock edge: pc=RESET_PC, inst=0 (NOP), inst_valid=0, fetch_count=0, state FETCH, imem_req=0 that cycle.
REQ-026 Reset mid-request abandons the request; an ack in the reset cycle is discarded.
REQ-027 First request issues in the first cycle with rst_n=1.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN defined: output align_err (1 bit, reset 0); redirect with branch_target[1:0]!=0 sets align_err sticky, leaves pc unchanged, enters HALT.
REQ-029 Macro undefined: no align_err port, HALT unreachable; redirect loads {branch_target[SIZE-1:2],2'b00}.

Structure
REQ-030 Shared package mips64_pkg holds SIZE default, RESET_PC default, INST_NOP constant and the FSM state encoding.
REQ-031 One sub-module, if_pc_reg: PC register plus next-PC mux (sequential/branch/hold); FSM and instruction register stay in fetch_unit.

Verification
REQ-032 Reset, RESET_PC=0, ack held 1, PCen=1 PCSrc=0 each VALID cycle -> pc 0,4,8,C; fetch_count 4 after four accepts.
REQ-033 pc=0x40, PCen=1 PCSrc=1 branch_target=0x100 -> next imem_addr=0x100, inst_valid low for at least one cycle.
REQ-034 ack delayed 3 cycles after req -> imem_req high 4 cycles, inst captured only on ack cycle, PCen during FETCH has no effect.
REQ-035 rst_n low while imem_req=1 and ack arriving same cycle -> inst=0, inst_valid=0, pc=RESET_PC next cycle.
REQ-036 FETCH_ALIGN_CHECK_EN: branch_target=0x102 -> align_err=1, HALT, imem_req=0 until reset; undefined: pc=0x100.
REQ-037 pc=0xFFFF_FFFF_FFFF_FFFC, sequential advance -> pc=0; fetch_count preset 0xFFFF_FFFF increments to 0.

Source files
------------

// File: rtl/mips64_pkg.sv
// Shared fetch-stage definitions: width/reset defaults, NOP encoding, FSM state and PC-select encodings.
package mips64_pkg;

  localparam int          SIZE_DEF     = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam logic [31:0] INST_NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ack/data back in the same or a later cycle.
interface fetch_unit_if #(
  parameter int SIZE = mips64_pkg::SIZE_DEF
);
  logic            imem_req;
  logic [SIZE-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_pc_reg.sv
// Program counter with sequential/branch/hold next-PC mux; updates one cycle after the select is driven.
module if_pc_reg
  import mips64_pkg::*;
#(
  parameter int              SIZE     = SIZE_DEF,
  parameter logic [SIZE-1:0] RESET_PC = SIZE'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         sel,
  input  logic [SIZE-1:0] branch_target,
  output logic [SIZE-1:0] pc
);

  logic [SIZE-1:0] pc_next;

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_SEQ:    pc_next = pc + SIZE'(4);
      // low bits dropped so the PC stays word aligned
      PC_BRANCH: pc_next = branch_target & ~(SIZE'(3));
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: FETCH->VALID->FETCH FSM, 1-cycle latency with zero-wait memory, holds inst until PCen.
// FETCH_ALIGN_CHECK_EN adds align_err: misaligned redirect halts until reset.
module fetch_unit
  import mips64_pkg::*;
#(
  parameter int              SIZE     = SIZE_DEF,
  parameter logic [SIZE-1:0] RESET_PC = SIZE'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCen,
  input  logic            PCSrc,
  input  logic [SIZE-1:0] branch_target,
  fetch_unit_if.master    imem,
  output logic [SIZE-1:0] inst,
  output logic            inst_valid,
  output logic [SIZE-1:0] pc,
  output logic [31:0]     fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            align_err
`endif
);

  fetch_state_e state, state_next;
  pc_sel_e      pc_sel;
  logic         inst_ld;
  logic         retire;
  logic [31:0]  inst_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         align_set;
`endif

  if_pc_reg #(
    .SIZE     (SIZE),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel           (pc_sel),
    .branch_target (branch_target),
    .pc            (pc)
  );

  always_comb begin
    state_next = state;
    pc_sel     = PC_HOLD;
    inst_ld    = 1'b0;
    retire     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    align_set  = 1'b0;
`endif
    case (state)
      FETCH: begin
        if (imem.imem_ack) begin
          inst_ld    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (PCen) begin
          retire     = 1'b1;
          state_next = FETCH;
          if (!PCSrc) pc_sel = PC_SEQ;
`ifdef FETCH_ALIGN_CHECK_EN
          else if (branch_target[1:0] != 2'b00) begin
            align_set  = 1'b1;
            state_next = HALT;
          end
`endif
          else pc_sel = PC_BRANCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // gated by rst_n so no request escapes while reset is asserted
  assign imem.imem_req  = (state == FETCH) && rst_n;
  assign imem.imem_addr = pc;
  assign inst           = {{(SIZE-32){1'b0}}, inst_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      inst_q      <= INST_NOP;
      inst_valid  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_next;
      if (inst_ld) begin
        inst_q     <= imem.imem_rdata;
        inst_valid <= 1'b1;
      end else if (retire) begin
        inst_valid <= 1'b0;
      end
      if (retire) fetch_count <= fetch_count + 32'd1;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else if (align_set) begin
      align_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, inst} queued on each accept, popped when inst_valid rises.
module tb_fetch_unit;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcen = 1'b0, pcsrc = 1'b0;
  logic [63:0] bt = 64'h0;
  logic [63:0] inst, pc;
  logic        inst_valid;
  logic [31:0] fetch_count;
  logic        pcen2 = 1'b0;
  logic [63:0] inst2, pc2;
  logic        inst_valid2;
  logic [31:0] fetch_count2;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_err, align_err2;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [63:0] pc_m = 64'h0;
  int          cnt_m = 0;
  bit          mem_always = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.SIZE(64)) bus ();
  fetch_unit_if #(.SIZE(64)) bus2 ();

  fetch_unit #(.SIZE(64), .RESET_PC(64'h0)) u_dut (
    .clk (clk), .rst_n (rst_n), .PCen (pcen), .PCSrc (pcsrc), .branch_target (bt),
    .imem (bus), .inst (inst), .inst_valid (inst_valid), .pc (pc), .fetch_count (fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
    , .align_err (align_err)
`endif
  );

  fetch_unit #(.SIZE(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .PCen (pcen2), .PCSrc (1'b0), .branch_target (64'h0),
    .imem (bus2), .inst (inst2), .inst_valid (inst_valid2), .pc (pc2), .fetch_count (fetch_count2)
`ifdef FETCH_ALIGN_CHECK_EN
    , .align_err (align_err2)
`endif
  );

  assign bus2.imem_ack   = 1'b1;
  assign bus2.imem_rdata = 32'h0000_0013;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A00_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: ack after ack_delay wait cycles, or ack held high in mem_always mode.
  always @(negedge clk) begin
    if (mem_always) begin
      bus.imem_ack = 1'b1;
    end else if (bus.imem_req) begin
      if (wait_cnt >= ack_delay) begin
        bus.imem_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.imem_ack = 1'b0;
      wait_cnt = 0;
    end
    bus.imem_rdata = mem_word(bus.imem_addr);
  end

  logic prev_valid = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (inst_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_inst", inst, e.inst);
      end
    end
    prev_valid = inst_valid;
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) check(tag, 64'd0, 64'd1);
  endtask

  // Called at a negedge while VALID; returns at the negedge after the accepting edge.
  task automatic accept(input bit src, input logic [63:0] tgt, input bit push);
    pcen = 1'b1; pcsrc = src; bt = tgt;
    @(negedge clk);
    pcen = 1'b0; pcsrc = 1'b0;
    cnt_m++;
    if (!src) pc_m = pc_m + 64'd4;
`ifdef FETCH_ALIGN_CHECK_EN
    else if (tgt[1:0] != 2'b00) pc_m = pc_m;
`endif
    else pc_m = tgt & ~64'h3;
    if (push) sb.push_back('{pc_m, {32'h0, mem_word(pc_m)}});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int reqs;
    // Reset values, request gated while in reset
    repeat (2) @(negedge clk);
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_pc", pc, 64'h0);
    check("rst_inst", inst, 64'h0);
    check("rst_count", fetch_count, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_align", align_err, 0);
`endif
    sb.push_back('{64'h0, {32'h0, mem_word(64'h0)}});
    rst_n = 1'b1;
    #1 check("req_first", bus.imem_req, 1);
    @(negedge clk);
    check("lat1_valid", inst_valid, 1);

    // Sequential stream with ack held high
    repeat (3) begin
      accept(1'b0, 64'h0, 1'b1);
      check("seq_drop", inst_valid, 0);
      wait_valid("seq_timeout");
    end
    repeat (3) @(negedge clk);
    check("hold_pc", pc, 64'hC);
    check("hold_req", bus.imem_req, 0);
    accept(1'b0, 64'h0, 1'b1);
    check("count4", fetch_count, 4);
    wait_valid("seq4_timeout");

    // Redirects
    accept(1'b1, 64'h40, 1'b1);
    wait_valid("br40_timeout");
    accept(1'b1, 64'h100, 1'b1);
    check("br_addr", bus.imem_addr, 64'h100);
    check("br_drop", inst_valid, 0);
    wait_valid("br100_timeout");

    // Slow memory; PCen/PCSrc driven during FETCH must be ignored
    mem_always = 1'b0;
    ack_delay  = 3;
    accept(1'b0, 64'h0, 1'b1);
    reqs = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) begin
      if (bus.imem_req) reqs++;
      if (i == 0) check("inst_hold", inst, {32'h0, mem_word(64'h100)});
      pcen = 1'b1; pcsrc = 1'b1; bt = 64'h800;
      @(negedge clk);
    end
    pcen = 1'b0; pcsrc = 1'b0;
    check("req_cycles", reqs, 4);
    check("slow_count", fetch_count, cnt_m);
    check("slow_pc", pc, 64'h104);

    // Reset while a request is outstanding and acked
    mem_always = 1'b1;
    accept(1'b0, 64'h0, 1'b0);
    check("mid_req", bus.imem_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_inst", inst, 64'h0);
    check("mid_valid", inst_valid, 0);
    check("mid_pc", pc, 64'h0);
    check("mid_count", fetch_count, 0);
    pc_m = 64'h0;
    cnt_m = 0;
    sb.push_back('{64'h0, {32'h0, mem_word(64'h0)}});
    rst_n = 1'b1;
    wait_valid("post_rst_timeout");

    // Misaligned redirect
`ifdef FETCH_ALIGN_CHECK_EN
    accept(1'b1, 64'h102, 1'b0);
    check("al_err", align_err, 1);
    check("al_req", bus.imem_req, 0);
    check("al_valid", inst_valid, 0);
    repeat (4) @(negedge clk);
    check("al_req_hold", bus.imem_req, 0);
    check("al_pc", pc, 64'h0);
    check("al_err_hold", align_err, 1);
`else
    accept(1'b1, 64'h102, 1'b1);
    wait_valid("al_timeout");
    check("al_pc", pc, 64'h100);
`endif

    // PC wrap at top of address space, counter wrap
    check("w_pc", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    check("w_valid", inst_valid2, 1);
    force u_dut2.fetch_count = 32'hFFFF_FFFF;
    #1 release u_dut2.fetch_count;
    pcen2 = 1'b1;
    @(negedge clk);
    pcen2 = 1'b0;
    check("w_pc0", pc2, 64'h0);
    check("w_count0", fetch_count2, 0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
